// File: rtl/a51_pkg.sv
// Shared A5/1 constants and the keystream-decipher state encoding.
package a51_pkg;
  localparam int MSG_BYTES   = 28;
  localparam int KS_OUT_BITS = MSG_BYTES * 8;
  localparam int KEY_BITS    = 64;
  localparam int FRAME_BITS  = 22;
  localparam int MIX_CYCLES  = 100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dec_state_e;
endpackage

// File: rtl/byte_fifo.sv
// First-word fall-through byte FIFO with occupancy counter and synchronous flush.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/a51_keystream_decipher.sv
// Packs the serial A5/1 keystream MSB-first into bytes, XORs each with the
// loaded message buffer and hands the results to the LCD path via valid/ready.
module a51_keystream_decipher #(
  parameter int MSG_BYTES  = a51_pkg::MSG_BYTES,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       msg_wr_en,
  input  logic [4:0] msg_wr_idx,
  input  logic [7:0] msg_wr_data,
  input  logic       start,
  input  logic       ks_valid,
  input  logic       ks_bit,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       overrun
);
  import a51_pkg::*;

  localparam logic [4:0] LAST_IDX = 5'(MSG_BYTES - 1);

  dec_state_e state_q, state_d;
  logic       start_q;
  logic [2:0] bit_cnt_q;
  logic [4:0] byte_idx_q;
  logic [7:0] shift_q;
  logic       overrun_q;
  logic [7:0] msg_buf [MSG_BYTES];

  logic       start_rise, arm, abort, ks_take, byte_done;
  logic [7:0] ks_byte;
  logic       f_push, f_pop, f_empty, f_full, drop;
  logic [7:0] f_head;

  assign start_rise = start && !start_q;
  assign arm        = start_rise && (state_q == ST_IDLE || state_q == ST_DONE);
  // Dropping start mid-run wins over any keystream bit in the same cycle.
  assign abort      = !start && (state_q == ST_RUN || state_q == ST_DRAIN);
  assign ks_take    = (state_q == ST_RUN) && start && ks_valid;
  assign byte_done  = ks_take && (bit_cnt_q == 3'd7);
  assign ks_byte    = {shift_q[6:0], ks_bit};

  assign f_push = byte_done;
  assign f_pop  = out_valid && out_ready;
  assign drop   = f_push && f_full && !f_pop;

  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign overrun   = overrun_q;
  assign out_valid = !f_empty;
  assign out_data  = f_empty ? 8'h00 : f_head;

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort),
    .push      (f_push),
    .push_data (ks_byte ^ msg_buf[byte_idx_q]),
    .pop       (f_pop),
    .head      (f_head),
    .empty     (f_empty),
    .full      (f_full)
  );

  // Buffer is deliberately outside reset so a message survives a reset.
  always_ff @(posedge clk) begin
    if (msg_wr_en && !busy && msg_wr_idx <= LAST_IDX)
      msg_buf[msg_wr_idx] <= msg_wr_data;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start_rise) state_d = ST_RUN;
      ST_RUN: begin
        if (abort)                                     state_d = ST_IDLE;
        else if (byte_done && byte_idx_q == LAST_IDX)  state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)        state_d = ST_IDLE;
        else if (f_empty) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      if (arm) begin
        bit_cnt_q  <= '0;
        byte_idx_q <= '0;
        overrun_q  <= 1'b0;
      end else if (ks_take) begin
        shift_q   <= ks_byte;
        bit_cnt_q <= bit_cnt_q + 3'd1;
        // Index advances even when the byte is dropped, keeping alignment.
        if (byte_done) byte_idx_q <= byte_idx_q + 5'd1;
        if (drop)      overrun_q  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_a51_keystream_decipher.sv
// Directed bench for a51_keystream_decipher with hand-computed expected bytes.
module tb_a51_keystream_decipher;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       msg_wr_en = 1'b0;
  logic [4:0] msg_wr_idx = '0;
  logic [7:0] msg_wr_data = '0;
  logic       start = 1'b0;
  logic       ks_valid = 1'b0;
  logic       ks_bit = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       busy, done, overrun;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] rx [$];

  a51_keystream_decipher #(.MSG_BYTES(28), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .msg_wr_en   (msg_wr_en),
    .msg_wr_idx  (msg_wr_idx),
    .msg_wr_data (msg_wr_data),
    .start       (start),
    .ks_valid    (ks_valid),
    .ks_bit      (ks_bit),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Record every accepted byte, sampled half a cycle before the popping edge.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) rx.push_back(out_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_buf(input int idx, input logic [7:0] d);
    msg_wr_en = 1'b1; msg_wr_idx = 5'(idx); msg_wr_data = d;
    tick();
    msg_wr_en = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    ks_valid = 1'b1; ks_bit = b;
    tick();
    ks_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic restart();
    start = 1'b0; tick();
    start = 1'b1; tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bp_exp [4];
    logic [7:0] bits_f3;
    int bad;
    bp_exp[0] = 8'h11; bp_exp[1] = 8'h32; bp_exp[2] = 8'h57; bp_exp[3] = 8'h74;

    // reset values
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_busy",      32'(busy),      0);
    chk("rst_done",      32'(done),      0);
    chk("rst_overrun",   32'(overrun),   0);
    reset = 1'b1;
    tick();

    // single byte: 0xB2 ^ 0x41 = 0xF3, visible right after the 8th bit edge
    wr_buf(0, 8'h41);
    start = 1'b1; tick();
    chk("t1_busy", 32'(busy), 1);
    bits_f3 = 8'hB2;
    for (int i = 7; i >= 1; i--) send_bit(bits_f3[i]);
    chk("t1_valid_early", 32'(out_valid), 0);
    send_bit(bits_f3[0]);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_data",  32'(out_data),  32'h0F3);
    start = 1'b0; tick();
    chk("t1_abort_valid", 32'(out_valid), 0);

    // full run of 28 bytes of alternating bits against a zero buffer
    for (int i = 0; i < 28; i++) wr_buf(i, 8'h00);
    rx.delete();
    out_ready = 1'b1;
    restart();
    for (int i = 0; i < 28; i++) send_byte(8'hAA);
    for (int i = 0; i < 10 && !done; i++) tick();
    chk("t2_done",    32'(done),    1);
    chk("t2_busy",    32'(busy),    0);
    chk("t2_overrun", 32'(overrun), 0);
    chk("t2_count",   32'(rx.size()), 28);
    bad = 0;
    foreach (rx[i]) if (rx[i] !== 8'hAA) bad++;
    chk("t2_bytes_bad", 32'(bad), 0);
    send_bit(1'b1);
    chk("t2_done_hold", 32'(done), 1);

    // backpressure: 5 bytes into a 4-deep FIFO, 5th dropped
    for (int i = 0; i < 6; i++) wr_buf(i, 8'(8'h10 + i));
    out_ready = 1'b0;
    rx.delete();
    restart();
    chk("t3_overrun_clr", 32'(overrun), 0);
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
    send_byte(8'h67); send_byte(8'h89);
    chk("t3_overrun", 32'(overrun),  1);
    chk("t3_head",    32'(out_data), 32'h11);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("t3_count4", 32'(rx.size()), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_byte%0d", i), 32'(rx[i]), 32'(bp_exp[i]));
    send_byte(8'hCD);
    tick(); tick();
    chk("t3_count5", 32'(rx.size()), 5);
    chk("t3_byte5",  32'(rx[4]), 32'hD8);
    start = 1'b0; tick();
    chk("t3_abort_busy",    32'(busy),    0);
    chk("t3_abort_done",    32'(done),    0);
    chk("t3_abort_overrun", 32'(overrun), 1);

    // gapped keystream: zeros offered while ks_valid=0 must not be captured
    wr_buf(0, 8'h0F);
    rx.delete();
    restart();
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1);
      ks_bit = 1'b0; tick();
    end
    tick();
    chk("t4_count", 32'(rx.size()), 1);
    chk("t4_byte",  32'(rx[0]), 32'hF0);

    // abort after 12 bits, restart re-aligns at byte 0; buffer write while busy ignored
    out_ready = 1'b0;
    restart();
    wr_buf(0, 8'hFF);
    send_byte(8'h5A);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("t5_pre_valid", 32'(out_valid), 1);
    start = 1'b0; tick();
    chk("t5_busy",  32'(busy),      0);
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_done",  32'(done),      0);
    restart();
    send_byte(8'hC3);
    chk("t5_realign", 32'(out_data), 32'hCC);

    // async reset mid-run with 3 bytes queued
    restart();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("t6_pre_valid", 32'(out_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_out_valid", 32'(out_valid), 0);
    chk("t6_out_data",  32'(out_data),  0);
    chk("t6_busy",      32'(busy),      0);
    chk("t6_done",      32'(done),      0);
    chk("t6_overrun",   32'(overrun),   0);
    start = 1'b0; tick();
    reset = 1'b1; tick();
    start = 1'b1; tick();
    send_byte(8'h00);
    chk("t6_buf_kept", 32'(out_data), 32'h0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
